// File: rtl/image_page_reader.sv
// Raster-order frame reader: fetches pixels from a 1-cycle-latency image page and streams them
// through a 2-entry FIFO. Define IMAGE_PAGE_READER_PAD_EN to add a 1-pixel zero border.
module image_page_reader #(
  parameter int ADDR_W = 13,
  parameter int PIX_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        img_width,
  input  logic [7:0]        img_height,
  output logic [ADDR_W-1:0] page_addr,
  output logic              need_Data,
  input  logic [79:0]       page_data,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_valid,
  output logic              pix_last,
  input  logic              pix_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              first_q, first_d;
  logic [8:0]        col_q, col_d, row_q, row_d;
  logic [8:0]        lastCol_q, lastCol_d, lastRow_q, lastRow_d;
  logic [8:0]        lastColInit, lastRowInit;
  logic              pipeValid_q, pipeValid_d;
  logic              pipeLast_q, pipeLast_d;
  logic              done_q, done_d;

  logic [PIX_W-1:0]  memData_q [2];
  logic              memLast_q [2];
  logic              wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [1:0]        count_q, count_d;

  logic              push, pop, issue, issueRead, isLastIssue, captureZero;
  logic [2:0]        pending;
  logic [ADDR_W-1:0] nextAddr;
  logic              unusedPageBits;

  assign unusedPageBits = ^page_data[79:PIX_W];

  // Pending work counts the beat leaving this cycle so a full pipeline still sustains 1 pixel/cycle.
  assign pop         = (count_q != 2'd0) && pix_ready;
  assign push        = pipeValid_q;
  assign pending     = {1'b0, count_q} - {2'b00, pop} + {2'b00, pipeValid_q};
  assign issue       = (state_q == READ) && (pending < 3'd2);
  assign isLastIssue = (col_q == lastCol_q) && (row_q == lastRow_q);
  assign nextAddr    = first_q ? base_q : addr_q + 1'b1;

`ifdef IMAGE_PAGE_READER_PAD_EN
  logic pipePad_q;
  logic isBorder;

  // Border positions travel down the same pipe as reads so stream order is preserved.
  assign isBorder    = (row_q == 9'd0) || (row_q == lastRow_q) ||
                       (col_q == 9'd0) || (col_q == lastCol_q);
  assign issueRead   = issue && !isBorder;
  assign captureZero = pipePad_q;
  assign lastColInit = {1'b0, img_width} + 9'd1;
  assign lastRowInit = {1'b0, img_height} + 9'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pipePad_q <= 1'b0;
    else     pipePad_q <= issue && isBorder;
  end
`else
  assign issueRead   = issue;
  assign captureZero = 1'b0;
  assign lastColInit = {1'b0, img_width} - 9'd1;
  assign lastRowInit = {1'b0, img_height} - 9'd1;
`endif

  assign need_Data = issueRead;
  assign page_addr = issueRead ? nextAddr : addr_q;
  assign pix_valid = (count_q != 2'd0);
  assign pix_data  = memData_q[rdPtr_q];
  assign pix_last  = pix_valid && memLast_q[rdPtr_q];
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    addr_d      = addr_q;
    first_d     = first_q;
    col_d       = col_q;
    row_d       = row_q;
    lastCol_d   = lastCol_q;
    lastRow_d   = lastRow_q;
    pipeValid_d = issue;
    pipeLast_d  = issue && isLastIssue;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (img_width == 8'd0 || img_height == 8'd0) begin
            done_d = 1'b1;
          end else begin
            state_d   = READ;
            base_d    = base_addr;
            first_d   = 1'b1;
            col_d     = 9'd0;
            row_d     = 9'd0;
            lastCol_d = lastColInit;
            lastRow_d = lastRowInit;
          end
        end
      end
      READ: begin
        if (issue) begin
          if (isLastIssue) state_d = DRAIN;
          if (col_q == lastCol_q) begin
            col_d = 9'd0;
            row_d = row_q + 9'd1;
          end else begin
            col_d = col_q + 9'd1;
          end
        end
      end
      DRAIN: begin
        if (pop && pix_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (issueRead) begin
      addr_d  = nextAddr;
      first_d = 1'b0;
    end
  end

  always_comb begin
    wrPtr_d = push ? ~wrPtr_q : wrPtr_q;
    rdPtr_d = pop ? ~rdPtr_q : rdPtr_q;
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      addr_q      <= '0;
      first_q     <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      lastCol_q   <= '0;
      lastRow_q   <= '0;
      pipeValid_q <= 1'b0;
      pipeLast_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      addr_q      <= addr_d;
      first_q     <= first_d;
      col_q       <= col_d;
      row_q       <= row_d;
      lastCol_q   <= lastCol_d;
      lastRow_q   <= lastRow_d;
      pipeValid_q <= pipeValid_d;
      pipeLast_q  <= pipeLast_d;
      done_q      <= done_d;
    end
  end

  // Page data arrives one cycle after the strobe and is written straight into the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      memData_q[0] <= '0;
      memData_q[1] <= '0;
      memLast_q[0] <= 1'b0;
      memLast_q[1] <= 1'b0;
      wrPtr_q      <= 1'b0;
      rdPtr_q      <= 1'b0;
      count_q      <= 2'd0;
    end else begin
      if (push) begin
        memData_q[wrPtr_q] <= captureZero ? '0 : page_data[PIX_W-1:0];
        memLast_q[wrPtr_q] <= pipeLast_q;
      end
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_image_page_reader.sv
// Self-checking bench for image_page_reader: directed and random frames against a raster-scan model.
// Follows IMAGE_PAGE_READER_PAD_EN to build padded or plain expected streams.
module tb_image_page_reader;

  localparam int ADDR_W = 13;
  localparam int PIX_W  = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [7:0]        img_width;
  logic [7:0]        img_height;
  logic [ADDR_W-1:0] page_addr;
  logic              need_Data;
  logic [79:0]       page_data;
  logic [PIX_W-1:0]  pix_data;
  logic              pix_valid;
  logic              pix_last;
  logic              pix_ready;
  logic              busy;
  logic              done;

  int tests  = 0;
  int failed = 0;

  logic [79:0] mem [DEPTH];

  always #5 clk = ~clk;

  image_page_reader #(.ADDR_W(ADDR_W), .PIX_W(PIX_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .img_width  (img_width),
    .img_height (img_height),
    .page_addr  (page_addr),
    .need_Data  (need_Data),
    .page_data  (page_data),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_last   (pix_last),
    .pix_ready  (pix_ready),
    .busy       (busy),
    .done       (done)
  );

  // Image page with one cycle of read latency; junk is driven when no read is pending.
  always @(posedge clk) begin
    if (need_Data) page_data <= mem[page_addr];
    else           page_data <= {16'($urandom), $urandom, $urandom};
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [ADDR_W-1:0] b, input logic [7:0] w, input logic [7:0] h);
    start      = s;
    base_addr  = b;
    img_width  = w;
    img_height = h;
  endtask

  function automatic logic nextReady(input int mode, input int k);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (k % 2) == 0;
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic runFrame(input logic [ADDR_W-1:0] b, input int w, input int h, input int mode, input int abortAfter);
    int expPix[$];
    int expAddr[$];
    int pad = 0;
    int nPix, sw, sh;
    int readIdx = 0;
    int beatIdx = 0;
    int doneCycle = -1;
    int lastBeatCycle = -1;
    int firstBeatCycle = -1;
    logic stalled = 1'b0;
    logic [PIX_W-1:0] heldData = '0;
    logic heldLast = 1'b0;
    bit aborted = 0;
    logic [ADDR_W-1:0] a13;
`ifdef IMAGE_PAGE_READER_PAD_EN
    pad = 1;
`endif
    if (w == 0 || h == 0) begin
      nPix = 0;
    end else begin
      sw = w + 2 * pad;
      sh = h + 2 * pad;
      for (int r = 0; r < sh; r++) begin
        for (int c = 0; c < sw; c++) begin
          if (pad == 1 && (r == 0 || r == sh - 1 || c == 0 || c == sw - 1)) begin
            expPix.push_back(0);
          end else begin
            a13 = ADDR_W'(int'(b) + (r - pad) * w + (c - pad));
            expAddr.push_back(int'(a13));
            expPix.push_back(int'(mem[a13][PIX_W-1:0]));
          end
        end
      end
      nPix = sw * sh;
    end

    for (int k = 0; k < 3000; k++) begin
      @(posedge clk);
      #1;
      if (k == 0)                    applyStimulus(1'b1, b, 8'(w), 8'(h));
      else if (k == 5 && nPix >= 4)  applyStimulus(1'b1, ~b, 8'd7, 8'd7);
      else                           applyStimulus(1'b0, b, 8'(w), 8'(h));
      pix_ready = nextReady(mode, k);
      #1;
      if (k == 0) checkOutput("idleBusy", 32'(busy), 32'd0);
      if (need_Data) begin
        if (readIdx < expAddr.size()) checkOutput("readAddr", 32'(page_addr), 32'(expAddr[readIdx]));
        else                          checkOutput("extraRead", 32'(need_Data), 32'd0);
        readIdx++;
      end
      if (stalled) begin
        checkOutput("stallValid", 32'(pix_valid), 32'd1);
        checkOutput("stallData", 32'(pix_data), 32'(heldData));
        checkOutput("stallLast", 32'(pix_last), 32'(heldLast));
      end
      if (pix_valid && pix_ready) begin
        if (beatIdx < nPix) begin
          checkOutput("beatData", 32'(pix_data), 32'(expPix[beatIdx]));
          checkOutput("beatLast", 32'(pix_last), 32'(beatIdx == nPix - 1));
        end else begin
          checkOutput("extraBeat", 32'(pix_valid && pix_ready), 32'd0);
        end
        if (firstBeatCycle < 0) firstBeatCycle = k;
        if (mode == 0) checkOutput("rate", 32'(k - firstBeatCycle), 32'(beatIdx));
        lastBeatCycle = k;
        beatIdx++;
      end
      stalled  = pix_valid && !pix_ready;
      heldData = pix_data;
      heldLast = pix_last;
      checkOutput("pending", 32'(readIdx - beatIdx <= 2), 32'd1);
      if (k >= 1 && doneCycle < 0 && beatIdx < nPix) checkOutput("busyHigh", 32'(busy), 32'd1);
      if (done) begin
        doneCycle = k;
        break;
      end
      if (abortAfter >= 0 && beatIdx == abortAfter) begin
        aborted = 1;
        break;
      end
    end
    start = 1'b0;

    if (aborted) begin
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      checkOutput("rstFlags", 32'({need_Data, pix_valid, pix_last, busy, done}), 32'd0);
      checkOutput("rstBuses", 32'({page_addr, pix_data}), 32'd0);
      repeat (2) begin
        @(negedge clk);
        checkOutput("rstNoDone", 32'(done), 32'd0);
      end
      @(negedge clk);
      rst = 1'b0;
      return;
    end

    checkOutput("doneSeen", 32'(doneCycle >= 0), 32'd1);
    checkOutput("readCount", 32'(readIdx), 32'(expAddr.size()));
    checkOutput("beatCount", 32'(beatIdx), 32'(nPix));
    if (nPix > 0) checkOutput("doneTiming", 32'(doneCycle), 32'(lastBeatCycle + 1));
    else          checkOutput("doneTiming", 32'(doneCycle), 32'd1);
    repeat (3) begin
      @(posedge clk);
      #2;
      checkOutput("postDone", 32'({done, busy, need_Data, pix_valid}), 32'd0);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]       = {16'($urandom), $urandom, $urandom};
      mem[i][7:0]  = 8'($urandom_range(1, 255));
    end
    rst       = 1'b1;
    pix_ready = 1'b0;
    applyStimulus(1'b0, '0, 8'd0, 8'd0);
    @(negedge clk);
    checkOutput("resetFlags", 32'({need_Data, pix_valid, pix_last, busy, done}), 32'd0);
    checkOutput("resetBuses", 32'({page_addr, pix_data}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    $display("[TB] base 100, 4x3, ready held high");
    runFrame(13'd100, 4, 3, 0, -1);
    $display("[TB] 4x3 with ready toggling");
    runFrame(13'd100, 4, 3, 1, -1);
    $display("[TB] address wrap from 8190");
    runFrame(13'd8190, 4, 1, 0, -1);
    runFrame(13'd8190, 4, 1, 2, -1);
    $display("[TB] zero-sized frames");
    runFrame(13'd50, 0, 3, 0, -1);
    runFrame(13'd50, 5, 0, 1, -1);
    $display("[TB] reset after 5 beats, then a full frame");
    runFrame(13'd200, 4, 3, 0, 5);
    runFrame(13'd300, 4, 3, 0, -1);
    $display("[TB] random frames");
    for (int n = 0; n < 6; n++) begin
      runFrame(ADDR_W'($urandom), $urandom_range(1, 6), $urandom_range(1, 5), 2, -1);
    end
`ifdef IMAGE_PAGE_READER_PAD_EN
    $display("[TB] padded 2x2 frame");
    runFrame(13'd500, 2, 2, 2, -1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/image_page_reader.md
IMAGE_PAGE_READER -- requirements
Module: image_page_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, the image page word-address width.
REQ-002 SHALL have parameter PIX_W, default 8, the pixel width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: one-cycle request to begin a frame read; honoured only in IDLE.
REQ-006 SHALL have port base_addr, input, ADDR_W bits: page address of pixel (0,0); sampled on an accepted start.
REQ-007 SHALL have ports img_width and img_height, input, 8 bits each: frame dimensions in pixels; sampled on an accepted start.
REQ-008 SHALL have port page_addr, output, ADDR_W bits: read address to the image page.
REQ-009 SHALL have port need_Data, output, 1 bit: page read strobe.
REQ-010 SHALL have port page_data, input, 80 bits: page read data; the pixel is page_data[PIX_W-1:0] and the upper bits are ignored.
REQ-011 SHALL have port pix_data, output, PIX_W bits: streamed pixel.
REQ-012 SHALL have ports pix_valid and pix_last, output, 1 bit each: pixel qualifier and final-pixel marker.
REQ-013 SHALL have port pix_ready, input, 1 bit: downstream accept.
REQ-014 SHALL have ports busy and done, output, 1 bit each: frame in progress, and a one-cycle end-of-frame pulse.

Function
REQ-015 SHALL implement the FSM IDLE -> READ -> DRAIN -> IDLE: start moves IDLE to READ; issuing the last read moves READ to DRAIN; acceptance of the pix_last beat moves DRAIN to IDLE.
REQ-016 SHALL scan in raster order, column fastest; the address of (r,c) is base_addr + r*img_width + c, formed by an incrementing counter (no multiplier) and wrapping modulo 2^ADDR_W.
REQ-017 SHALL treat page read latency as exactly 1 cycle: the data for the read strobed in cycle N is captured at the clk edge ending cycle N+1.
REQ-018 SHALL buffer captured pixels in a 2-entry FIFO and issue a read only when FIFO occupancy plus in-flight reads is less than 2, so that no data is ever dropped.
REQ-019 SHALL hold need_Data low whenever no read is issued; page_addr SHALL hold its last value when idle.
REQ-020 SHALL drive pix_valid high whenever the FIFO is non-empty; a beat transfers on pix_valid & pix_ready, and pix_data/pix_last SHALL stay stable while pix_valid is high and pix_ready is low.
REQ-021 SHALL assert pix_last only with the final pixel of the frame.
REQ-022 SHALL pulse done for one cycle in the cycle after the pix_last transfer; busy SHALL be high from the cycle after an accepted start until done.
REQ-023 SHALL, when img_width or img_height is 0, go directly to IDLE, pulse done once, and issue no reads.
REQ-024 SHALL ignore start while busy.
REQ-025 SHALL sustain 1 pixel per cycle when pix_ready is held high.

Reset
REQ-026 SHALL, on rst, asynchronously force IDLE, empty the FIFO, clear in-flight reads, and drive need_Data, pix_valid, pix_last, busy and done to 0, and page_addr and pix_data to 0.
REQ-027 SHALL, when rst is asserted mid-frame, abandon the frame without a done pulse and accept a new start after release.

Configuration
REQ-028 SHALL support macro IMAGE_PAGE_READER_PAD_EN: when defined, the stream is (img_width+2)x(img_height+2) with a 1-pixel zero border; border pixels are inserted into the FIFO without a page read, and interior addressing is per REQ-016.
REQ-029 SHALL, when IMAGE_PAGE_READER_PAD_EN is undefined, stream exactly img_width x img_height pixels with no padding logic.

Verification
REQ-030 SHALL cover base_addr=100, 4x3 frame, pix_ready=1 -> 12 reads at addresses 100..111, 12 beats at 1 beat/cycle, pix_last on beat 12, done one cycle later.
REQ-031 SHALL cover 4x3 frame with pix_ready toggling 1/0 each cycle -> no lost or duplicated pixel, data stable while stalled, and never more than 2 pixels pending (FIFO plus in-flight).
REQ-032 SHALL cover base_addr=8190, 4x1 frame -> addresses 8190, 8191, 0, 1.
REQ-033 SHALL cover img_width=0 -> no need_Data pulse, done pulse, return to IDLE.
REQ-034 SHALL cover rst asserted after 5 beats of a 4x3 frame -> all outputs 0 immediately; a new start then streams a full frame.
REQ-035 SHALL cover IMAGE_PAGE_READER_PAD_EN with a 2x2 frame -> 16 beats; only the 4 interior beats are non-zero page data, read from base_addr..base_addr+3.
